// File: rtl/traffic_ctrl.sv
// Frogger lane scheduler: shared prescaler, per-lane step dividers, level progression and game-over.
// Optional macro PAUSE_ENABLE_EN adds a pause input and PAUSED state.
module traffic_ctrl #(
  parameter int LANES     = 4,
  parameter int CNT_W     = 9,
  parameter int MAX_LEVEL = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hit,
  input  logic             frog_home,
`ifdef PAUSE_ENABLE_EN
  input  logic             pause,
`endif
  output logic [LANES-1:0] step,
  output logic [LANES-1:0] dir,
  output logic             freeze,
  output logic [2:0]       level,
  output logic             game_over
);

`ifdef PAUSE_ENABLE_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LVL, S_GG, S_PAUSED} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LVL, S_GG} state_t;
`endif

  localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_presc;
  logic [2:0]       r_level, w_level_next;
  logic [LANES-1:0] r_step, r_dir, w_wrap, w_lane_odd;
  logic             r_freeze, r_game_over;
  logic             w_count, w_clear, w_base_tick;

  assign w_base_tick = (r_presc == {CNT_W{1'b1}});

  // w_count: lanes advance this cycle; w_clear: round restart after a level-up
  always_comb begin
    w_state_next = r_state;
    w_count      = 1'b0;
    w_clear      = 1'b0;
    w_level_next = r_level;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (hit)            w_state_next = S_GG;
        else if (frog_home) w_state_next = S_LVL;
`ifdef PAUSE_ENABLE_EN
        else if (pause)     w_state_next = S_PAUSED;
`endif
        else                w_count = 1'b1;
      end
      S_LVL: begin
        w_clear      = 1'b1;
        w_level_next = (r_level >= LVL_MAX) ? LVL_MAX : r_level + 3'd1;
        w_state_next = hit ? S_GG : S_RUN;
      end
      S_GG: begin
        w_state_next = S_GG;
      end
`ifdef PAUSE_ENABLE_EN
      // Resuming counts in the release cycle so a pause of N cycles shifts the schedule by N.
      S_PAUSED: begin
        if (hit) begin
          w_state_next = S_GG;
        end else if (!pause) begin
          w_state_next = S_RUN;
          w_count      = 1'b1;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_level     <= 3'd0;
      r_step      <= '0;
      r_dir       <= w_lane_odd;
      r_freeze    <= 1'b1;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_step      <= w_wrap;
      r_dir       <= w_lane_odd ^ {LANES{w_level_next[0]}};
      r_freeze    <= (w_state_next != S_RUN);
      r_game_over <= (w_state_next == S_GG);
      if (w_clear)      r_presc <= '0;
      else if (w_count) r_presc <= r_presc + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [3:0] BASE = 4'(gi + 4);
      logic [3:0] r_cnt;
      logic [3:0] w_period;

      // Period i+4-level clamped at 1 without letting the subtraction wrap.
      assign w_period      = (BASE > ({1'b0, r_level} + 4'd1)) ? (BASE - {1'b0, r_level}) : 4'd1;
      assign w_wrap[gi]    = w_count & w_base_tick & (r_cnt == w_period - 4'd1);
      assign w_lane_odd[gi] = 1'(gi % 2);

      always_ff @(posedge clk) begin
        if (reset || w_clear) begin
          r_cnt <= 4'd0;
        end else if (w_count && w_base_tick) begin
          r_cnt <= w_wrap[gi] ? 4'd0 : r_cnt + 4'd1;
        end
      end
    end
  endgenerate

  assign step      = r_step;
  assign dir       = r_dir;
  assign freeze    = r_freeze;
  assign level     = r_level;
  assign game_over = r_game_over;

endmodule
